// File: rtl/alu_result_tx_serializer.sv
// Captures WIDTH-bit results and streams them LSB byte first to a UART TX (optional ALU_TX_DROPCNT_EN adds drop_cnt).
// Latency: res_valid at edge N -> tx_valid after edge N+1 when TX is idle; one result held plus one in flight.
// Backpressure: tx_busy stalls each byte; a result arriving while the holding register is full is dropped.
module alu_result_tx_serializer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] res_in,
  input  logic             res_valid,
  input  logic             tx_busy,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  output logic             pending
`ifdef ALU_TX_DROPCNT_EN
  ,
  output logic [7:0]       drop_cnt
`endif
);

  localparam int NBYTES = WIDTH / 8;
  localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] hold;
  logic             hv;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_shift;
  logic [CW-1:0]    cnt;
  logic             load;
  logic             next_byte;

  assign sr_shift = sr >> 8;
  assign pending  = hv | (state != IDLE);

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    next_byte = 1'b0;
    case (state)
      IDLE: begin
        if (hv && !tx_busy) begin
          load      = 1'b1;
          state_nxt = WAIT_ACK;
        end
      end
      WAIT_ACK: state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (cnt != '0) begin
            next_byte = 1'b1;
            state_nxt = WAIT_ACK;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A load frees the holding register on the same edge, so a new word may refill it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold <= '0;
      hv   <= 1'b0;
    end else if (res_valid && (!hv || load)) begin
      hold <= res_in;
      hv   <= 1'b1;
    end else if (load) begin
      hv   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr       <= '0;
      cnt      <= '0;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
    end else begin
      tx_valid <= load | next_byte;
      if (load) begin
        sr      <= hold;
        cnt     <= CW'(NBYTES - 1);
        tx_data <= hold[7:0];
      end else if (next_byte) begin
        sr      <= sr_shift;
        cnt     <= cnt - CW'(1);
        tx_data <= sr_shift[7:0];
      end
    end
  end

`ifdef ALU_TX_DROPCNT_EN
  logic drop;
  assign drop = res_valid && hv && !load;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt <= 8'h00;
    end else if (drop && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_result_tx_serializer.sv
// Bench for alu_result_tx_serializer: a UART TX model with a 10-cycle busy window, plus a WIDTH=32 instance with an always-ready TX.
module tb_alu_result_tx_serializer;

  localparam int BUSY = 10;

  logic        clk;
  logic        rst;
  logic [15:0] res_in;
  logic        res_valid;
  logic        tx_busy;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        pending;
  logic        force_busy;
  logic        model_busy;

  logic [31:0] res_in32;
  logic        res_valid32;
  logic        busy32;
  logic [7:0]  tx_data32;
  logic        tx_valid32;
  logic        pending32;

`ifdef ALU_TX_DROPCNT_EN
  logic [7:0]  drop_cnt;
  logic [7:0]  drop_cnt32;
`endif

  int          checks;
  int          errors;
  int          viol;
  logic [7:0]  got[$];
  logic [7:0]  got32[$];

  typedef struct {
    logic [15:0] word;
    logic [7:0]  b0;
    logic [7:0]  b1;
  } vec_t;
  vec_t vecs[5];

  assign tx_busy = force_busy | model_busy;

  alu_result_tx_serializer #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .res_in(res_in), .res_valid(res_valid),
    .tx_busy(tx_busy), .tx_data(tx_data), .tx_valid(tx_valid), .pending(pending)
`ifdef ALU_TX_DROPCNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  alu_result_tx_serializer #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .res_in(res_in32), .res_valid(res_valid32),
    .tx_busy(busy32), .tx_data(tx_data32), .tx_valid(tx_valid32), .pending(pending32)
`ifdef ALU_TX_DROPCNT_EN
    , .drop_cnt(drop_cnt32)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // TX model: sample strobes on the falling edge, then hold busy for BUSY cycles.
  initial begin
    int  busy_left;
    logic prev;
    busy_left  = 0;
    prev       = 1'b0;
    viol       = 0;
    model_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_valid && prev) viol++;
      prev = tx_valid;
      if (tx_valid) begin
        got.push_back(tx_data);
        busy_left = BUSY;
      end else if (busy_left > 0) begin
        busy_left--;
      end
      model_busy = (busy_left > 0);
      if (tx_valid32) got32.push_back(tx_data32);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse(input logic [15:0] w);
    res_in    = w;
    res_valid = 1'b1;
    @(negedge clk);
    res_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((pending || tx_busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check({name, "_idle_timeout"}, (n < 200), 1);
  endtask

  task automatic wait_bytes(input int cnt, input string name);
    int n;
    n = 0;
    while (got.size() < cnt && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_strobe_timeout"}, (n < 200), 1);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    res_in      = '0;
    res_valid   = 1'b0;
    force_busy  = 1'b0;
    res_in32    = '0;
    res_valid32 = 1'b0;
    busy32      = 1'b0;

    vecs[0] = '{16'h1234, 8'h34, 8'h12};
    vecs[1] = '{16'h00FF, 8'hFF, 8'h00};
    vecs[2] = '{16'hA55A, 8'h5A, 8'hA5};
    vecs[3] = '{16'hFFFF, 8'hFF, 8'hFF};
    vecs[4] = '{16'h8001, 8'h01, 8'h80};

    #1 rst = 1'b0;
    #2;
    check("rst_tx_valid", {31'd0, tx_valid}, 0);
    check("rst_tx_data", {24'd0, tx_data}, 0);
    check("rst_pending", {31'd0, pending}, 0);
`ifdef ALU_TX_DROPCNT_EN
    check("rst_drop_cnt", {24'd0, drop_cnt}, 0);
`endif
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Table-driven single words, including idle-TX latency.
    for (int i = 0; i < 5; i++) begin
      got.delete();
      res_in    = vecs[i].word;
      res_valid = 1'b1;
      @(negedge clk);
      res_valid = 1'b0;
      check("lat_early", {31'd0, tx_valid}, 0);
      check("lat_pending", {31'd0, pending}, 1);
      @(negedge clk);
      check("lat_strobe", {31'd0, tx_valid}, 1);
      wait_bytes(2, "vec");
      @(negedge clk);
      check("vec_pending_busy", {31'd0, pending}, 1);
      wait_idle("vec");
      check("vec_count", got.size(), 2);
      if (got.size() == 2) begin
        check("vec_b0", {24'd0, got[0]}, {24'd0, vecs[i].b0});
        check("vec_b1", {24'd0, got[1]}, {24'd0, vecs[i].b1});
      end
      check("vec_pending_end", {31'd0, pending}, 0);
    end

    // Back-to-back: second word refills the holding register on the load edge.
    got.delete();
    res_in    = 16'hAAAA;
    res_valid = 1'b1;
    @(negedge clk);
    res_in    = 16'h0003;
    @(negedge clk);
    res_valid = 1'b0;
    wait_bytes(4, "b2b");
    wait_idle("b2b");
    check("b2b_count", got.size(), 4);
    if (got.size() == 4) begin
      check("b2b_0", {24'd0, got[0]}, 32'hAA);
      check("b2b_1", {24'd0, got[1]}, 32'hAA);
      check("b2b_2", {24'd0, got[2]}, 32'h03);
      check("b2b_3", {24'd0, got[3]}, 32'h00);
    end
`ifdef ALU_TX_DROPCNT_EN
    check("b2b_drop_cnt", {24'd0, drop_cnt}, 0);
`endif

    // Overflow: third word arrives while hold is full and the FSM is busy.
    got.delete();
    res_in    = 16'hA1A2;
    res_valid = 1'b1;
    @(negedge clk);
    res_in    = 16'hB1B2;
    @(negedge clk);
    res_in    = 16'hC1C2;
    @(negedge clk);
    res_valid = 1'b0;
    wait_bytes(4, "ovf");
    wait_idle("ovf");
    check("ovf_count", got.size(), 4);
    if (got.size() == 4) begin
      check("ovf_0", {24'd0, got[0]}, 32'hA2);
      check("ovf_1", {24'd0, got[1]}, 32'hA1);
      check("ovf_2", {24'd0, got[2]}, 32'hB2);
      check("ovf_3", {24'd0, got[3]}, 32'hB1);
    end
`ifdef ALU_TX_DROPCNT_EN
    check("ovf_drop_cnt", {24'd0, drop_cnt}, 1);
`endif

    // Stall: busy held before the word arrives, strobe one cycle after release.
    got.delete();
    force_busy = 1'b1;
    @(negedge clk);
    pulse(16'h5566);
    repeat (5) @(negedge clk);
    check("stall_no_strobe", got.size(), 0);
    check("stall_pending", {31'd0, pending}, 1);
    force_busy = 1'b0;
    @(negedge clk);
    check("stall_strobe", {31'd0, tx_valid}, 1);
    check("stall_data", {24'd0, tx_data}, 32'h66);
    wait_idle("stall");
    check("stall_count", got.size(), 2);

    // Saturation: one word held under busy, then 300 drops; leftover feeds the reset test.
    got.delete();
    force_busy = 1'b1;
    @(negedge clk);
    res_in    = 16'h9876;
    res_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      res_in = 16'(i);
    end
    @(negedge clk);
    res_valid = 1'b0;
`ifdef ALU_TX_DROPCNT_EN
    check("sat_drop_cnt", {24'd0, drop_cnt}, 32'hFF);
`endif
    check("sat_no_strobe", got.size(), 0);

    // Reset between bytes of the held word.
    force_busy = 1'b0;
    wait_bytes(1, "rstmid");
    check("rstmid_first", {24'd0, got[0]}, 32'h76);
    repeat (3) @(negedge clk);
    check("rstmid_pre_pending", {31'd0, pending}, 1);
    #2 rst = 1'b0;
    #1;
    check("rstmid_tx_data", {24'd0, tx_data}, 0);
    check("rstmid_tx_valid", {31'd0, tx_valid}, 0);
    check("rstmid_pending", {31'd0, pending}, 0);
`ifdef ALU_TX_DROPCNT_EN
    check("rstmid_drop_cnt", {24'd0, drop_cnt}, 0);
`endif
    @(negedge clk);
    got.delete();
    rst = 1'b1;
    repeat (30) @(negedge clk);
    check("rstmid_no_residual", got.size(), 0);
    check("rstmid_pending_after", {31'd0, pending}, 0);

    // WIDTH=32 instance with TX always ready.
    got32.delete();
    res_in32    = 32'hDEADBEEF;
    res_valid32 = 1'b1;
    @(negedge clk);
    res_valid32 = 1'b0;
    repeat (20) @(negedge clk);
    check("w32_count", got32.size(), 4);
    if (got32.size() == 4) begin
      check("w32_0", {24'd0, got32[0]}, 32'hEF);
      check("w32_1", {24'd0, got32[1]}, 32'hBE);
      check("w32_2", {24'd0, got32[2]}, 32'hAD);
      check("w32_3", {24'd0, got32[3]}, 32'hDE);
    end
    check("w32_pending", {31'd0, pending32}, 0);

    check("no_consecutive_valid", viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
